// File: rtl/imm_btarget_pipe.sv
// imm_btarget_pipe
//   Two-stage valid/ready pipeline for the decode/operand-fetch path.
//   For each accepted {instruction, pc} it produces:
//     - the branch target: pc + (sext(instr[OFF_W-1:0]) << SHAMT), wrapping at XLEN bits
//     - the expanded immediate selected by the modifier bits instr[IMM_W+1:IMM_W]:
//         00 sign-extend, 01 zero-extend, 10 place in the upper bits, 11 illegal (imm 0, err 1)
//     - a saturating count of illegal modifiers delivered downstream
//
//   Optional feature macro: IMM_BTARGET_RET_EN
//     When defined, out_ret_addr = pc + (1 << SHAMT) is produced in stage 2
//     (link-register value for calls). When undefined the port and its adder are absent.
//
//   Ports
//     clk, rst_n          rising-edge clock, asynchronous active-low reset
//     flush               synchronous kill of both stages and of this cycle's input
//     in_valid/in_ready   input handshake, in_instr (32b) and in_pc (XLEN)
//     out_valid/out_ready output handshake
//     out_btarget         branch target
//     out_imm             expanded immediate
//     out_imm_err         modifier was 2'b11
//     err_cnt             saturating illegal-modifier count (delivered results only)
//     out_ret_addr        return address (IMM_BTARGET_RET_EN only)
//
//   Handshake: a transfer happens on a rising edge where valid && ready. Stage 2
//   advances when it is empty or the consumer takes its result; stage 1 advances
//   when it is empty or stage 2 advances. in_ready is stage 1's advance condition,
//   so it depends combinationally on out_ready (no skid buffer). While a result is
//   offered and not taken, every out_* signal holds its value.
module imm_btarget_pipe #(
  parameter int XLEN  = 32,
  parameter int OFF_W = 27,
  parameter int IMM_W = 16,
  parameter int SHAMT = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_btarget,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_imm_err,
  output logic [CNT_W-1:0] err_cnt
`ifdef IMM_BTARGET_RET_EN
  ,
  output logic [XLEN-1:0]  out_ret_addr
`endif
);

  // ---------------------------------------------------------------------------
  // Field decode (combinational, ahead of stage 1)
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0] off_fld;
  logic [IMM_W-1:0] imm_fld;
  logic [1:0]       mod_fld;
  logic [XLEN-1:0]  off_sext;
  logic [XLEN-1:0]  imm_exp;
  logic             imm_err;

  assign off_fld  = in_instr[OFF_W-1:0];
  assign imm_fld  = in_instr[IMM_W-1:0];
  assign mod_fld  = in_instr[IMM_W+1:IMM_W];
  // Size cast of a signed operand sign-extends to XLEN.
  assign off_sext = XLEN'($signed(off_fld));

  // Upper instruction bits are not decoded here; fold them so lint sees them used.
  logic unused_instr;
  assign unused_instr = ^in_instr;

  always_comb begin
    imm_exp = '0;
    imm_err = 1'b0;
    case (mod_fld)
      2'b00:   imm_exp = XLEN'($signed(imm_fld));
      2'b01:   imm_exp = XLEN'(imm_fld);
      2'b10:   imm_exp = XLEN'(imm_fld) << (XLEN - IMM_W);
      default: begin
        // Illegal modifier: drive a defined zero rather than anything derived from the field.
        imm_exp = '0;
        imm_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: pc, sign-extended offset, expanded immediate, error flag
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] s1_pc;
  logic [XLEN-1:0] s1_off;
  logic [XLEN-1:0] s1_imm;
  logic            s1_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_off   <= '0;
      s1_imm   <= '0;
      s1_err   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid;
      end
      // Data is captured only on a real accept; a flushed input is dropped.
      if (s1_adv && in_valid && !flush) begin
        s1_pc  <= in_pc;
        s1_off <= off_sext;
        s1_imm <= imm_exp;
        s1_err <= imm_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: target adder (and optional return-address incrementer)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] s2_btarget;
  logic [XLEN-1:0] s2_imm;
  logic            s2_err;

`ifdef IMM_BTARGET_RET_EN
  localparam logic [XLEN-1:0] RET_INC = XLEN'(1) << SHAMT;
  logic [XLEN-1:0] s2_ret;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_btarget <= '0;
      s2_imm     <= '0;
      s2_err     <= 1'b0;
`ifdef IMM_BTARGET_RET_EN
      s2_ret     <= '0;
`endif
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv && s1_valid && !flush) begin
        // Carry out of XLEN is discarded: targets wrap around the address space.
        s2_btarget <= s1_pc + (s1_off << SHAMT);
        s2_imm     <= s1_imm;
        s2_err     <= s1_err;
`ifdef IMM_BTARGET_RET_EN
        s2_ret     <= s1_pc + RET_INC;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Illegal-modifier counter: counts delivered results only, saturates at all-ones.
  // A result being flushed in the same cycle is not counted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && s2_err && !flush && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = s2_valid;
  assign out_btarget = s2_btarget;
  assign out_imm     = s2_imm;
  assign out_imm_err = s2_err;
`ifdef IMM_BTARGET_RET_EN
  assign out_ret_addr = s2_ret;
`endif

endmodule
